// File: rtl/fib_control_unit.sv
// Fibonacci sequencer: steps ALU + 4-entry register file one opcode per clock, Moore outputs.
// Result lands in R2; DONE arrives 1 (n=0), 5 (n=1) or 6+4(n-2) cycles after start is accepted.
module fib_control_unit #(
   parameter int size = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [size-1:0] n,
   input  logic            zero_flag,
   output logic [2:0]      alu_opcode,
   output logic [1:0]      rd_sel1,
   output logic [1:0]      rd_sel2,
   output logic [1:0]      wr_sel,
   output logic            wr_en,
   output logic [size-1:0] ext_data,
   output logic            busy,
   output logic            done,
   output logic            err
);

   localparam logic [2:0] OP_NOOP  = 3'b000;
   localparam logic [2:0] OP_SET   = 3'b001;
   localparam logic [2:0] OP_DEC   = 3'b011;
   localparam logic [2:0] OP_LOAD  = 3'b100;
   localparam logic [2:0] OP_STORE = 3'b101;
   localparam logic [2:0] OP_ADD   = 3'b110;
   localparam logic [2:0] OP_COPY  = 3'b111;

   typedef enum logic [3:0] {
      IDLE, LOADN, SET1, SET2, DECI, DEC, ADD, CPY1, CPY2, DONE
   } state_t;

   state_t          state, state_nxt;
   logic [size-1:0] n_lat;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         n_lat <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start)
            n_lat <= n;
      end
   end

   // R0 counter, R1 F(k-1), R2 F(k), R3 temp
   always_comb begin
      state_nxt  = state;
      alu_opcode = OP_NOOP;
      rd_sel1    = 2'd0;
      rd_sel2    = 2'd0;
      wr_sel     = 2'd0;
      wr_en      = 1'b0;
      ext_data   = '0;
      busy       = 1'b1;
      done       = 1'b0;
      err        = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start)
               state_nxt = (n == '0) ? DONE : LOADN;
         end
         LOADN: begin
            alu_opcode = OP_LOAD;
            ext_data   = n_lat;
            wr_en      = 1'b1;
            state_nxt  = SET1;
         end
         SET1: begin
            alu_opcode = OP_SET;
            wr_sel     = 2'd1;
            wr_en      = 1'b1;
            state_nxt  = SET2;
         end
         SET2: begin
            alu_opcode = OP_SET;
            wr_sel     = 2'd2;
            wr_en      = 1'b1;
            state_nxt  = DECI;
         end
         DECI, DEC: begin
            // zero_flag reflects R0-1 in this cycle: counter exhausted
            alu_opcode = OP_DEC;
            wr_en      = 1'b1;
            if (zero_flag)
               state_nxt = DONE;
            else
               state_nxt = (state == DECI) ? DEC : ADD;
         end
         ADD: begin
            alu_opcode = OP_ADD;
            rd_sel1    = 2'd1;
            rd_sel2    = 2'd2;
            wr_sel     = 2'd3;
            wr_en      = 1'b1;
            state_nxt  = CPY1;
         end
         CPY1: begin
            alu_opcode = OP_COPY;
            rd_sel1    = 2'd2;
            wr_sel     = 2'd1;
            wr_en      = 1'b1;
            state_nxt  = CPY2;
         end
         CPY2: begin
            alu_opcode = OP_COPY;
            rd_sel1    = 2'd3;
            wr_sel     = 2'd2;
            wr_en      = 1'b1;
            state_nxt  = DEC;
         end
         DONE: begin
            alu_opcode = OP_STORE;
            rd_sel1    = 2'd2;
            done       = 1'b1;
            err        = (n_lat == '0);
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: doc/fib_control_unit.md
# fib_control_unit

Sequencer that drives the 4-bit ALU and a 4-entry register file to compute the n-th Fibonacci number. It issues one ALU opcode per clock, steers the register-file read/write selects, consumes the ALU zero flag to terminate the loop, and reports completion. It sits between the top-level start/n inputs and the datapath (ALU plus register file R0..R3).

## Interface
- size, 4, width of n, ext_data and the datapath word
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request to compute; sampled only in IDLE
- n  input  size  term index (F1=F2=1); latched when start is accepted
- zero_flag  input  1  ALU zero flag (combinational from current opcode/operands)
- alu_opcode  output  3  000 noop, 001 set, 010 inc, 011 dec, 100 load, 101 store, 110 add, 111 copy
- rd_sel1  output  2  register-file read port 1 → ALU reg1
- rd_sel2  output  2  register-file read port 2 → ALU reg2
- wr_sel  output  2  register-file write address
- wr_en  output  1  register-file write enable
- ext_data  output  size  value the datapath writes when opcode=load (load muxes ext_data in place of ALU_out)
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse in DONE
- err  output  1  high with done when n=0

## Operation
- Register map: R0 loop counter, R1 F(k-1), R2 F(k), R3 temp.
- States and per-state outputs (Moore, decoded from state register; unlisted selects = 0, wr_en = 0):
  - IDLE: noop. start=1 and n≠0 → LOADN; start=1 and n=0 → DONE with err; latch n in n_lat either way.
  - LOADN: load, ext_data=n_lat, wr_sel=0, wr_en=1 → SET1.
  - SET1: set, wr_sel=1, wr_en=1 → SET2.
  - SET2: set, wr_sel=2, wr_en=1 → DECI.
  - DECI: dec, rd_sel1=0, wr_sel=0, wr_en=1; zero_flag=1 → DONE, else → DEC.
  - DEC: same outputs as DECI; zero_flag=1 → DONE, else → ADD.
  - ADD: add, rd_sel1=1, rd_sel2=2, wr_sel=3, wr_en=1 → CPY1.
  - CPY1: copy, rd_sel1=2, wr_sel=1, wr_en=1 → CPY2.
  - CPY2: copy, rd_sel1=3, wr_sel=2, wr_en=1 → DEC.
  - DONE: store, rd_sel1=2 (result visible on ALU_out), wr_en=0, done=1, err=(n_lat==0) → IDLE.
- Result is R2 at DONE. Arithmetic is modulo 2^size, no overflow detection; for size=4, n≤7 is exact (F7=13), n=8 wraps to 5.
- start outside IDLE is ignored; n changes after acceptance have no effect.
- n=0: no register writes, err=1, result undefined.

## Timing
- Reset (async, any state): state=IDLE, n_lat=0; outputs: alu_opcode=000, all selects 0, wr_en=0, ext_data=0, busy=0, done=0, err=0. Reset mid-computation abandons it; register file contents are not restored.
- zero_flag is sampled at the rising edge that ends DECI/DEC.
- Cycle 0 = edge that accepts start. DONE occupies cycle: n=0 → 1; n=1 → 5; n≥2 → 6+4(n-2). Back in IDLE one cycle after DONE; a new start may be accepted on that edge's following cycle.
- One register write per cycle max; write takes effect at the end of the state's cycle.

## Test plan
- Reset during CPY1 of an n=5 run → outputs immediately reset values, busy=0; next start with n=5 completes normally, done at cycle 18, ALU_out=5.
- n=1 → opcode sequence load,set,set,dec,store; done at cycle 5, err=0, R2=1.
- n=7 → done at cycle 26, R2=13, ALU_out=13 in DONE; busy high cycles 1..26.
- n=0 → done and err high at cycle 1, wr_en never asserted.
- n=8 → done at cycle 30, R2=5 (wrap of 21).
- start held high continuously with n=3 → runs back-to-back; start ignored while busy, second done exactly 11 cycles after first, each R2=2.
